// File: rtl/fir1_interp2.sv
`default_nettype none
// ============================================================================
// Module   : fir1_interp2
// Purpose  : 2x polyphase interpolating FIR. Each accepted signed input
//            sample produces one output pair: y0 (even phase, taps a[2k])
//            and y1 (odd phase, taps a[2k+1]) of a fixed 16-tap symmetric
//            low-pass filter with Q16 coefficients. After the stream starts,
//            the first 7 accepts only prime the delay line. Each later accept
//            yields an output pair one cycle after the handshake.
// Ports    : clk, rst           - rising-edge clock, synchronous active-high reset
//            enable             - stream active; low flushes back to IDLE
//            x_valid/x_ready/x  - input handshake and signed N-bit sample
//            busy               - high while priming the delay line
//            valid/y_ready      - output handshake
//            y0, y1             - even / odd phase outputs, signed N-bit
// Revision : 1.0 - initial release
// ============================================================================
module fir1_interp2 #(
    parameter int N     = 32,
    parameter int SHIFT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                x_valid,
    output logic                x_ready,
    input  logic signed [N-1:0] x,
    output logic                busy,
    output logic                valid,
    input  logic                y_ready,
    output logic signed [N-1:0] y0,
    output logic signed [N-1:0] y1
);

    // Accumulator is wide enough for 8 products of an N-bit sample and an
    // 18-bit coefficient plus growth, so the sum never wraps.
    localparam int c_acc_w  = N + 24;
    localparam int c_coef_w = 18;
    localparam int c_taps   = 8;
    localparam int c_line   = 8;

    // Even phase: a[0], a[2], ... a[14]; odd phase: a[1], a[3], ... a[15].
    localparam logic signed [c_coef_w-1:0] c_coef_even [c_taps] = '{
        -18'sd157, -18'sd399,  18'sd3466, -18'sd1987,
         18'sd36857, -18'sd4548, -18'sd838, 18'sd380
    };
    localparam logic signed [c_coef_w-1:0] c_coef_odd [c_taps] = '{
         18'sd380, -18'sd838, -18'sd4548, 18'sd36857,
        -18'sd1987, 18'sd3466, -18'sd399, -18'sd157
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Registers and their next-state values
    // ------------------------------------------------------------------
    state_t                state_q;
    state_t                state_d;
    logic [2:0]            cnt_q;
    logic [2:0]            cnt_d;
    logic signed [N-1:0]   d_q [c_line];
    logic signed [N-1:0]   d_d [c_line];
    logic                  valid_q;
    logic                  valid_d;
    logic signed [N-1:0]   y0_q;
    logic signed [N-1:0]   y0_d;
    logic signed [N-1:0]   y1_q;
    logic signed [N-1:0]   y1_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_produce;
    logic signed [N-1:0]   w_tap [c_taps];
    logic signed [c_acc_w-1:0] w_acc0;
    logic signed [c_acc_w-1:0] w_acc1;
    logic                  w_unused_bits;

    // Ready does not look at x_valid; a pending output that is not being
    // drained blocks new input so the held pair is never overwritten.
    assign w_ready  = enable && (state_q != S_IDLE) && (!valid_q || y_ready);
    assign w_accept = x_valid && w_ready;

    assign x_ready = w_ready;
    assign busy    = (state_q == S_FILL);
    assign valid   = valid_q;
    assign y0      = y0_q;
    assign y1      = y1_q;

    // Taps see the line as it will be after this accept: the incoming
    // sample followed by the seven newest stored samples.
    always_comb begin
        w_tap[0] = x;
        for (int k = 1; k < c_taps; k++) begin
            w_tap[k] = d_q[k-1];
        end
    end

    // Both phases share the same tap vector.
    always_comb begin
        w_acc0 = '0;
        w_acc1 = '0;
        for (int k = 0; k < c_taps; k++) begin
            w_acc0 = w_acc0 + (c_acc_w'(w_tap[k]) * c_acc_w'(c_coef_even[k]));
            w_acc1 = w_acc1 + (c_acc_w'(w_tap[k]) * c_acc_w'(c_coef_odd[k]));
        end
    end

    // Bits below the Q16 point, above the output window, and the oldest
    // line entry (shifted in but never tapped) are deliberately dropped.
    assign w_unused_bits = ^{w_acc0[SHIFT-1:0], w_acc0[c_acc_w-1:SHIFT+N],
                             w_acc1[SHIFT-1:0], w_acc1[c_acc_w-1:SHIFT+N],
                             d_q[c_line-1]};

    // ------------------------------------------------------------------
    // Next-state / datapath control
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        d_d       = d_q;
        valid_d   = valid_q;
        y0_d      = y0_q;
        y1_d      = y1_q;
        w_produce = 1'b0;

        case (state_q)
            S_IDLE: begin
                state_d = S_FILL;
            end
            S_FILL: begin
                if (w_accept) begin
                    // The eighth accept completes priming and is also the
                    // first one to produce an output pair.
                    if (cnt_q == 3'd7) begin
                        state_d   = S_RUN;
                        w_produce = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            S_RUN: begin
                w_produce = w_accept;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_accept) begin
            d_d[0] = x;
            for (int k = 1; k < c_line; k++) begin
                d_d[k] = d_q[k-1];
            end
        end

        // A new pair replaces a draining one in the same cycle, keeping
        // valid high for full throughput.
        if (w_produce) begin
            valid_d = 1'b1;
            y0_d    = w_acc0[SHIFT +: N];
            y1_d    = w_acc1[SHIFT +: N];
        end else if (valid_q && y_ready) begin
            valid_d = 1'b0;
        end

        // Dropping enable discards any pending output and re-primes from a
        // zeroed line; y0/y1 keep their last values.
        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            d_d     = '{default: '0};
            valid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d_q     <= '{default: '0};
            valid_q <= 1'b0;
            y0_q    <= '0;
            y1_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            valid_q <= valid_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
        end
    end

endmodule
`default_nettype wire
